// File: rtl/instr_encoder_loader.sv
// Encodes LEGv8 instruction field bundles into 32-bit machine words and streams them
// into instruction memory at consecutive byte addresses through a stall-able write port.
module instr_encoder_loader #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [25:0]       in_imm,
    input  logic [5:0]        in_shamt,
    input  logic              in_last,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-2:0] count,
    output logic              err_invalid,
    output logic              err_full
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [ADDR_W-2:0] CntMax = (ADDR_W-1)'(DEPTH);
    localparam logic [ADDR_W-2:0] CntOne = (ADDR_W-1)'(1);
    localparam logic [ADDR_W-1:0] CapW   = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(4);

    logic [1:0]        state_q, state_d;
    logic              enc_valid_q, enc_valid_d;
    logic [31:0]       enc_word_q, enc_word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-2:0] count_q, count_d;
    logic              err_invalid_q, err_invalid_d;
    logic              err_full_q, err_full_d;
    logic              last_seen_q, last_seen_d;

    logic [31:0]       enc_word;
    logic              op_ok;
    logic [ADDR_W-1:0] fill;
    logic [ADDR_W-2:0] cnt_inc;
    logic              wr_hs;
    logic              in_hs;

    always_comb begin
        enc_word = '0;
        op_ok    = 1'b1;
        case (in_op)
            4'd0:    enc_word = {10'b1001000100, in_imm[11:0], in_rn, in_rd};
            4'd1:    enc_word = {11'b10101011000, in_rm, 6'b0, in_rn, in_rd};
            4'd2:    enc_word = {11'b10001010000, in_rm, 6'b0, in_rn, in_rd};
            4'd3:    enc_word = {6'b000101, in_imm};
            4'd4:    enc_word = {8'b01010100, in_imm[18:0], 5'b01011};
            4'd5:    enc_word = {8'b10110100, in_imm[18:0], in_rd};
            4'd6:    enc_word = {11'b11001010000, in_rm, 6'b0, in_rn, in_rd};
            4'd7:    enc_word = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
            4'd8:    enc_word = {11'b11010011010, 5'b0, in_shamt, in_rn, in_rd};
            4'd9:    enc_word = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
            4'd10:   enc_word = {11'b11101011000, in_rm, 6'b0, in_rn, in_rd};
            default: op_ok = 1'b0;
        endcase
    end

    // Words written plus the one in flight must stay below capacity to accept another.
    assign fill    = {1'b0, count_q} + {{(ADDR_W-1){1'b0}}, enc_valid_q};
    assign cnt_inc = count_q + CntOne;
    assign in_ready = (state_q == StLoad) && (!enc_valid_q || mem_ready) && (fill < CapW)
                      && !last_seen_q;
    assign wr_hs = enc_valid_q && mem_ready;
    assign in_hs = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        enc_valid_d   = enc_valid_q;
        enc_word_d    = enc_word_q;
        addr_d        = addr_q;
        count_d       = count_q;
        err_invalid_d = err_invalid_q;
        err_full_d    = err_full_q;
        last_seen_d   = last_seen_q;
        if (start) begin
            state_d       = StLoad;
            enc_valid_d   = 1'b0;
            enc_word_d    = '0;
            addr_d        = '0;
            count_d       = '0;
            err_invalid_d = 1'b0;
            err_full_d    = 1'b0;
            last_seen_d   = 1'b0;
        end else if (state_q == StLoad) begin
            if (wr_hs) begin
                enc_valid_d = 1'b0;
                count_d     = cnt_inc;
                // Hold the address at the last slot instead of wrapping to zero.
                if (cnt_inc != CntMax) begin
                    addr_d = addr_q + AddrStep;
                end
                if (last_seen_q) begin
                    state_d = StDone;
                end else if (cnt_inc == CntMax) begin
                    err_full_d = 1'b1;
                    state_d    = StDone;
                end
            end
            if (in_hs) begin
                if (in_last) begin
                    last_seen_d = 1'b1;
                end
                if (op_ok) begin
                    enc_valid_d = 1'b1;
                    enc_word_d  = enc_word;
                end else begin
                    err_invalid_d = 1'b1;
                    if (in_last) begin
                        state_d = StDone;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            enc_valid_q   <= 1'b0;
            enc_word_q    <= '0;
            addr_q        <= '0;
            count_q       <= '0;
            err_invalid_q <= 1'b0;
            err_full_q    <= 1'b0;
            last_seen_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            enc_valid_q   <= enc_valid_d;
            enc_word_q    <= enc_word_d;
            addr_q        <= addr_d;
            count_q       <= count_d;
            err_invalid_q <= err_invalid_d;
            err_full_q    <= err_full_d;
            last_seen_q   <= last_seen_d;
        end
    end

    assign mem_wr_en   = enc_valid_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = enc_word_q;
    assign busy        = (state_q == StLoad);
    assign done        = (state_q == StDone);
    assign count       = count_q;
    assign err_invalid = err_invalid_q;
    assign err_full    = err_full_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a spec-level encoder model plus a write scoreboard
// checks every memory write; a small DEPTH=4 instance covers the capacity limit.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_rd = '0, in_rn = '0, in_rm = '0;
    logic [25:0] in_imm = '0;
    logic [5:0]  in_shamt = '0;
    logic        in_last = 1'b0;
    logic        mem_ready = 1'b1;

    logic        in_ready_a, mem_wr_en_a, busy_a, done_a, err_invalid_a, err_full_a;
    logic [11:0] mem_addr_a;
    logic [31:0] mem_wr_data_a;
    logic [10:0] count_a;

    logic        in_ready_b, mem_wr_en_b, busy_b, done_b, err_invalid_b, err_full_b;
    logic [3:0]  mem_addr_b;
    logic [31:0] mem_wr_data_b;
    logic [2:0]  count_b;

    int n_checks = 0;
    int n_fail = 0;
    logic use_b = 1'b0;
    logic [31:0] exp_q[$];
    int model_count = 0;
    int nb_writes = 0;
    logic prev_stall = 1'b0;
    logic [11:0] prev_addr;
    logic [31:0] prev_data;

    always #5 clk = ~clk;

    instr_encoder_loader #(.DEPTH(1024), .ADDR_W(12)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .in_shamt(in_shamt), .in_last(in_last), .mem_wr_en(mem_wr_en_a), .mem_addr(mem_addr_a),
        .mem_wr_data(mem_wr_data_a), .mem_ready(mem_ready), .busy(busy_a), .done(done_a),
        .count(count_a), .err_invalid(err_invalid_a), .err_full(err_full_a)
    );

    instr_encoder_loader #(.DEPTH(4), .ADDR_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .in_shamt(in_shamt), .in_last(in_last), .mem_wr_en(mem_wr_en_b), .mem_addr(mem_addr_b),
        .mem_wr_data(mem_wr_data_b), .mem_ready(mem_ready), .busy(busy_b), .done(done_b),
        .count(count_b), .err_invalid(err_invalid_b), .err_full(err_full_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Opcode/field placement taken straight from the instruction format table.
    function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rd,
                                           input logic [4:0] rn, input logic [4:0] rm,
                                           input logic [25:0] imm, input logic [5:0] shamt);
        logic [31:0] d, n, m, i, s;
        d = 32'(rd);
        n = 32'(rn) << 5;
        m = 32'(rm) << 16;
        i = 32'(imm);
        s = 32'(shamt) << 10;
        case (op)
            4'd0:    return (32'h244 << 22) | ((i % 4096) << 10) | n | d;
            4'd1:    return (32'h558 << 21) | m | n | d;
            4'd2:    return (32'h450 << 21) | m | n | d;
            4'd3:    return (32'h5 << 26) | i;
            4'd4:    return (32'h54 << 24) | ((i % 524288) << 5) | 32'd11;
            4'd5:    return (32'hB4 << 24) | ((i % 524288) << 5) | d;
            4'd6:    return (32'h650 << 21) | m | n | d;
            4'd7:    return (32'h7C2 << 21) | ((i % 512) << 12) | n | d;
            4'd8:    return (32'h69A << 21) | s | n | d;
            4'd9:    return (32'h7C0 << 21) | ((i % 512) << 12) | n | d;
            4'd10:   return (32'h758 << 21) | m | n | d;
            default: return 32'h0;
        endcase
    endfunction

    // Scoreboard: every write handshake must match the next expected word at 4*index.
    always @(negedge clk) begin
        if (reset || start_a) begin
            exp_q.delete();
            model_count = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_en", {31'b0, mem_wr_en_a}, 32'd1);
                chk("stall_hold_addr", {20'b0, mem_addr_a}, {20'b0, prev_addr});
                chk("stall_hold_data", mem_wr_data_a, prev_data);
            end
            if (busy_a) chk("count_track", {21'b0, count_a}, model_count);
            prev_stall = 1'b0;
            if (mem_wr_en_a) begin
                if (!mem_ready) begin
                    chk("stall_in_ready", {31'b0, in_ready_a}, 32'd0);
                    prev_stall = 1'b1;
                    prev_addr = mem_addr_a;
                    prev_data = mem_wr_data_a;
                end else if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                             mem_addr_a, mem_wr_data_a);
                end else begin
                    chk("write_data", mem_wr_data_a, exp_q.pop_front());
                    chk("write_addr", {20'b0, mem_addr_a}, 4 * model_count);
                    model_count++;
                end
            end
        end
        if (!reset && mem_wr_en_b && mem_ready) nb_writes++;
    end

    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [25:0] imm, input logic [5:0] shamt,
                        input logic last, input int max_tries, output logic acc,
                        output int tries);
        in_op = op; in_rd = rd; in_rn = rn; in_rm = rm;
        in_imm = imm; in_shamt = shamt; in_last = last;
        in_valid = 1'b1;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < max_tries) begin
            @(negedge clk);
            acc = use_b ? in_ready_b : in_ready_a;
            if (acc && !use_b && op <= 4'd10) exp_q.push_back(encode(op, rd, rn, rm, imm, shamt));
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
    endtask

    int total_tries = 0;

    task automatic put(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic [25:0] imm, input logic [5:0] shamt,
                       input logic last);
        logic acc;
        int tries;
        send(op, rd, rn, rm, imm, shamt, last, 20, acc, tries);
        total_tries += tries;
        chk("accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    task automatic wait_done_a();
        int k = 0;
        while (!done_a && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("done_reached", {31'b0, done_a}, 32'd1);
        chk("all_words_written", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int tries;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy_a}, 32'd0);
        chk("rst_done", {31'b0, done_a}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready_a}, 32'd0);
        chk("rst_wr_en", {31'b0, mem_wr_en_a}, 32'd0);
        chk("rst_addr", {20'b0, mem_addr_a}, 32'd0);
        chk("rst_count", {21'b0, count_a}, 32'd0);
        chk("rst_errs", {30'b0, err_invalid_a, err_full_a}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Pin the model against hand-assembled words.
        chk("model_addi", encode(4'd0, 5'd4, 5'd1, 5'd0, 26'd24, 6'd0), 32'h91006024);
        chk("model_b", encode(4'd3, 5'd0, 5'd0, 5'd0, 26'd32, 6'd0), 32'h14000020);
        chk("model_blt", encode(4'd4, 5'd0, 5'd0, 5'd0, 26'd16, 6'd0), 32'h5400020B);
        chk("model_lsr", encode(4'd8, 5'd2, 5'd4, 5'd0, 26'd0, 6'd2), 32'hD3400882);
        chk("model_stur", encode(4'd9, 5'd4, 5'd2, 5'd0, 26'd4, 6'd0), 32'hF8004044);
        chk("model_subs", encode(4'd10, 5'd5, 5'd1, 5'd31, 26'd0, 6'd0), 32'hEB1F0025);

        // Single ADDI with last.
        pulse_start_a();
        chk("start_busy", {31'b0, busy_a}, 32'd1);
        put(4'd0, 5'd4, 5'd1, 5'd0, 26'd24, 6'd0, 1'b1);
        chk("addi_wr_en", {31'b0, mem_wr_en_a}, 32'd1);
        chk("addi_addr", {20'b0, mem_addr_a}, 32'd0);
        chk("addi_data", mem_wr_data_a, 32'h91006024);
        @(posedge clk);
        #1;
        chk("addi_done", {31'b0, done_a}, 32'd1);
        chk("addi_busy", {31'b0, busy_a}, 32'd0);
        chk("addi_count", {21'b0, count_a}, 32'd1);

        // Back-to-back burst.
        pulse_start_a();
        total_tries = 0;
        put(4'd3, 5'd0, 5'd0, 5'd0, 26'd32, 6'd0, 1'b0);
        put(4'd4, 5'd9, 5'd0, 5'd0, 26'd16, 6'd0, 1'b0);
        put(4'd8, 5'd2, 5'd4, 5'd0, 26'd0, 6'd2, 1'b0);
        put(4'd9, 5'd4, 5'd2, 5'd0, 26'd4, 6'd0, 1'b0);
        put(4'd10, 5'd5, 5'd1, 5'd31, 26'd0, 6'd0, 1'b1);
        chk("burst_one_per_cycle", total_tries, 32'd5);
        wait_done_a();
        chk("burst_count", {21'b0, count_a}, 32'd5);

        // Burst with mem_ready low for 3 cycles.
        pulse_start_a();
        fork
            begin
                put(4'd1, 5'd1, 5'd2, 5'd3, 26'd0, 6'd0, 1'b0);
                put(4'd2, 5'd4, 5'd5, 5'd6, 26'd0, 6'd0, 1'b0);
                put(4'd5, 5'd7, 5'd0, 5'd0, 26'h7FFFF, 6'd0, 1'b0);
                put(4'd7, 5'd8, 5'd9, 5'd0, 26'h3FF, 6'd0, 1'b1);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                mem_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                mem_ready = 1'b1;
            end
        join
        wait_done_a();
        chk("stall_count", {21'b0, count_a}, 32'd4);

        // Invalid opcode between two valid ones.
        pulse_start_a();
        put(4'd0, 5'd1, 5'd0, 5'd0, 26'd5, 6'd0, 1'b0);
        put(4'd13, 5'd2, 5'd2, 5'd2, 26'd0, 6'd0, 1'b0);
        put(4'd6, 5'd3, 5'd1, 5'd2, 26'd0, 6'd0, 1'b1);
        wait_done_a();
        chk("inv_err", {31'b0, err_invalid_a}, 32'd1);
        chk("inv_count", {21'b0, count_a}, 32'd2);

        // Restart mid-session: next write goes to address 0.
        pulse_start_a();
        chk("restart_err_clr", {31'b0, err_invalid_a}, 32'd0);
        put(4'd0, 5'd1, 5'd1, 5'd0, 26'd1, 6'd0, 1'b0);
        put(4'd0, 5'd2, 5'd2, 5'd0, 26'd2, 6'd0, 1'b0);
        pulse_start_a();
        put(4'd0, 5'd3, 5'd3, 5'd0, 26'd3, 6'd0, 1'b1);
        chk("restart_addr", {20'b0, mem_addr_a}, 32'd0);
        chk("restart_wr_en", {31'b0, mem_wr_en_a}, 32'd1);
        wait_done_a();
        chk("restart_count", {21'b0, count_a}, 32'd1);

        // DEPTH=4 instance: six bundles without last.
        use_b = 1'b1;
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send(4'd0, 5'(k), 5'd0, 5'd0, 26'(k), 6'd0, 1'b0, 6, acc, tries);
            chk($sformatf("small_accept_%0d", k), {31'b0, acc}, (k < 4) ? 32'd1 : 32'd0);
        end
        chk("small_writes", nb_writes, 32'd4);
        chk("small_err_full", {31'b0, err_full_b}, 32'd1);
        chk("small_done", {31'b0, done_b}, 32'd1);
        chk("small_in_ready", {31'b0, in_ready_b}, 32'd0);
        chk("small_count", {29'b0, count_b}, 32'd4);
        use_b = 1'b0;

        // Reset while a write is stalled.
        pulse_start_a();
        mem_ready = 1'b0;
        put(4'd3, 5'd0, 5'd0, 5'd0, 26'd7, 6'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_stalled", {31'b0, mem_wr_en_a}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        chk("rst_stall_wr_en", {31'b0, mem_wr_en_a}, 32'd0);
        chk("rst_stall_count", {21'b0, count_a}, 32'd0);
        chk("rst_stall_idle", {30'b0, busy_a, done_a}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_write", {31'b0, mem_wr_en_a}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
